matrix_fifo_loader: RTL and testbench

Write side of the matrix-vector datapath: fetches the 8x8 matrix A and the 8-element vector B from a word-addressed memory and streams them byte-by-byte into the nine input FIFOs consumed by the MAC array. Each 64-bit memory word holds one row of A (words 0..7) or vector B (word 8). The loader unpacks each word and writes its bytes into the matching FIFO, honouring each FIFO's full flag, then signals completion.

---
 rtl/minilab_pkg.sv | 18 +
 rtl/matrix_fifo_loader.sv | 118 +++++++++++
 tb/tb_matrix_fifo_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/minilab_pkg.sv
// Shared constants and types for the Minilab1 matrix-vector datapath.
// DATA_WIDTH : element width (one FIFO entry)
// NUM_ROWS   : rows of A and elements per row; the loader feeds NUM_ROWS+1 FIFOs
// load_state_e : matrix_fifo_loader FSM states
package minilab_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned NUM_ROWS   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StWrite,
    StDone
  } load_state_e;

endpackage

// File: rtl/matrix_fifo_loader.sv
// matrix_fifo_loader: fetches NUM_ROWS rows of A plus vector B (one memory word each) and
// streams every word byte-by-byte, most-significant byte first, into its own input FIFO.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   start               level-sampled in idle; begins a load
//   busy, done          busy outside idle; done pulses once after the last byte
//   mem_address/read    word read request, held until mem_waitrequest is low
//   mem_waitrequest     request not accepted this cycle
//   mem_readdata/valid  returned word
//   fifo_data           shared byte bus to all FIFOs
//   fifo_wrreq          one-hot write strobe, bit NUM_ROWS is the B FIFO
//   fifo_wrfull         per-FIFO full flags
module matrix_fifo_loader #(
  parameter int unsigned DATA_WIDTH = minilab_pkg::DATA_WIDTH,
  parameter int unsigned NUM_ROWS   = minilab_pkg::NUM_ROWS,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic                           mem_read,
  input  logic                           mem_waitrequest,
  input  logic [DATA_WIDTH*NUM_ROWS-1:0] mem_readdata,
  input  logic                           mem_readdatavalid,
  output logic [DATA_WIDTH-1:0]          fifo_data,
  output logic [NUM_ROWS:0]              fifo_wrreq,
  input  logic [NUM_ROWS:0]              fifo_wrfull
);
  import minilab_pkg::*;

  localparam int unsigned WordW = DATA_WIDTH * NUM_ROWS;
  // Row counter must reach NUM_ROWS+1 to signal the end of the load.
  localparam int unsigned RowW  = $clog2(NUM_ROWS + 2);
  localparam int unsigned ColW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(NUM_ROWS - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(NUM_ROWS);

  load_state_e      state_q, state_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [WordW-1:0] word_q, word_d;
  logic             write_en;

  // wrfull gates the strobe in the same cycle so a full FIFO is never written.
  assign write_en = (state_q == StWrite) && !fifo_wrfull[row_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        row_d = '0;
        col_d = '0;
        if (start) state_d = StReq;
      end
      StReq: begin
        if (!mem_waitrequest) state_d = StWait;
      end
      StWait: begin
        if (mem_readdatavalid) begin
          word_d  = mem_readdata;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (write_en) begin
          // Shift left so the next column is always in the top byte.
          word_d = word_q << DATA_WIDTH;
          if (col_q == LastCol) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = (row_q == LastRow) ? StDone : StReq;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    mem_read    = (state_q == StReq);
    mem_address = mem_read ? (BASE_ADDR + ADDR_WIDTH'(row_q)) : '0;
    fifo_data   = word_q[WordW-1 -: DATA_WIDTH];
    fifo_wrreq  = '0;
    if (write_en) fifo_wrreq[row_q] = 1'b1;
  end

endmodule

// File: tb/tb_matrix_fifo_loader.sv
// Self-checking bench for matrix_fifo_loader: a memory/FIFO responder with random and directed
// wait states, latency and full flags, and a transaction-level model of the expected behaviour.
module tb_matrix_fifo_loader;

  localparam int unsigned NR = 8;
  localparam int unsigned NF = NR + 1;
  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] BASE = 32'h0000_0040;
  localparam int BASE_CYCLES = 1 + NF * (NR + 2);

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, mem_read, mem_waitrequest, mem_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [63:0]   mem_readdata;
  logic [7:0]    fifo_data;
  logic [NF-1:0] fifo_wrreq, fifo_wrfull;

  matrix_fifo_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .fifo_data         (fifo_data),
    .fifo_wrreq        (fifo_wrreq),
    .fifo_wrfull       (fifo_wrfull)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  // Memory image: words 0..NR-1 are rows of A, word NR is B.
  logic [63:0] mem [0:NF-1];

  // Reference model state (written only by the compare process).
  bit         loading = 0;
  bit         awaiting = 0;
  int         t0 = 0, extra = 0, req_row = 0, avail = 0, wr_row = 0, wr_col = 0;
  int         ndone = 0, done_rel = 0;
  logic [7:0] wlog [0:NF-1][0:NR-1];

  always @(negedge clk) begin : cmp
    logic          exp_rd;
    logic [NF-1:0] exp_wr;
    logic [63:0]   w;
    if (!rst_n) begin
      loading = 0; awaiting = 0; avail = 0; req_row = 0; wr_row = 0; wr_col = 0; extra = 0;
    end else begin
      exp_rd = loading && !awaiting && avail == 0 && req_row <= NR;
      chk("busy", busy, loading);
      chk("done", done, loading && cyc == t0 + BASE_CYCLES + extra);
      chk("mem_read", mem_read, exp_rd);
      if (exp_rd) chk("mem_address", mem_address, BASE + AW'(req_row));
      exp_wr = '0;
      if (avail > 0) begin
        if (!fifo_wrfull[wr_row]) exp_wr[wr_row] = 1'b1;
        else extra++;
      end
      chk("fifo_wrreq", fifo_wrreq, exp_wr);
      if (exp_wr != '0) begin
        w = mem[wr_row];
        chk("fifo_data", fifo_data, w[63 - 8 * wr_col -: 8]);
        wlog[wr_row][wr_col] = fifo_data;
        avail--;
        wr_col++;
        if (wr_col == NR) begin wr_col = 0; wr_row++; end
      end
      if (awaiting) begin
        if (mem_readdatavalid) begin awaiting = 0; avail = NR; end
        else extra++;
      end
      if (exp_rd) begin
        if (mem_waitrequest) extra++;
        else begin awaiting = 1; req_row++; end
      end
      if (loading && cyc == t0 + BASE_CYCLES + extra) begin
        loading = 0; done_rel = cyc - t0; ndone++;
      end else if (!loading && start) begin
        loading = 1; t0 = cyc; extra = 0; req_row = 0; wr_row = 0; wr_col = 0;
      end
    end
  end

  // Responder knobs.
  int wait_pct = 0, lat_max = 0, full_pct = 0, stray_pct = 0;
  int dwait_row = -1, dwait_left = 0;
  int dfull_fifo = -1, dfull_after = 0, dfull_left = 0, dfull_cnt = 0;
  int pend = 0, pend_row = 0;

  task automatic clear_knobs();
    wait_pct = 0; lat_max = 0; full_pct = 0; stray_pct = 0;
    dwait_row = -1; dwait_left = 0;
    dfull_fifo = -1; dfull_after = 0; dfull_left = 0; dfull_cnt = 0;
  endtask

  // One clock: observe the cycle at the falling edge, then drive inputs 1 time unit after rise.
  task automatic tick();
    @(negedge clk);
    if (rst_n && mem_read && !mem_waitrequest) begin
      pend = 1 + $urandom_range(0, lat_max);
      pend_row = int'(mem_address - BASE);
    end
    if (dfull_fifo >= 0 && fifo_wrreq[dfull_fifo]) dfull_cnt++;
    @(posedge clk);
    #1;
    mem_readdatavalid = 1'b0;
    mem_readdata = {$urandom, $urandom};
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = mem[pend_row];
      end
    end else if ($urandom_range(0, 99) < stray_pct) begin
      mem_readdatavalid = 1'b1;
    end
    mem_waitrequest = 1'b0;
    if (mem_read) begin
      if (dwait_row >= 0 && mem_address == BASE + AW'(dwait_row) && dwait_left > 0) begin
        mem_waitrequest = 1'b1;
        dwait_left--;
      end else if ($urandom_range(0, 99) < wait_pct) begin
        mem_waitrequest = 1'b1;
      end
    end
    for (int i = 0; i < NF; i++) fifo_wrfull[i] = ($urandom_range(0, 99) < full_pct);
    if (dfull_fifo >= 0 && dfull_cnt >= dfull_after && dfull_left > 0) begin
      fifo_wrfull[dfull_fifo] = 1'b1;
      dfull_left--;
    end
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = ndone;
    for (int i = 0; i < budget && ndone == n0; i++) tick();
    chk("load_completed", ndone > n0, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < NF; r++)
      for (int c = 0; c < NR; c++) mem[r][63 - 8 * c -: 8] = 8'(8 * r + c + 1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < NF; r++) mem[r] = {$urandom, $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_mem_read"}, mem_read, 1'b0);
    chk({tag, "_mem_address"}, mem_address, '0);
    chk({tag, "_fifo_wrreq"}, fifo_wrreq, '0);
    chk({tag, "_fifo_data"}, fifo_data, '0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; start = 1'b0; mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
    mem_readdata = '0; fifo_wrfull = '0;
    clear_knobs();
    #1;
    check_reset_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Zero-wait load with a known byte pattern.
    fill_pattern();
    pulse_start();
    wait_done(300);
    chk("t1_done_cycle", done_rel, 91);
    for (int r = 0; r < NF; r++)
      for (int c = 0; c < NR; c++) chk("t1_fifo_byte", wlog[r][c], 64'(8 * r + c + 1));
    repeat (3) tick();

    // Three waitrequest cycles on row 2.
    fill_random();
    dwait_row = 2; dwait_left = 3;
    pulse_start();
    wait_done(300);
    chk("t2_done_cycle", done_rel, 94);
    clear_knobs();
    repeat (3) tick();

    // FIFO 4 full for five cycles after its third byte.
    fill_random();
    dfull_fifo = 4; dfull_after = 3; dfull_left = 5;
    pulse_start();
    wait_done(300);
    chk("t3_done_cycle", done_rel, 96);
    clear_knobs();
    repeat (3) tick();

    // Reset during row 3 writes, then a fresh load from row 0.
    fill_pattern();
    pulse_start();
    for (int i = 0; i < 200 && !(mem_read && mem_address == BASE + 3); i++) tick();
    chk("t4_reached_row3", mem_address, BASE + 3);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t4_reset");
    pend = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    fill_random();
    pulse_start();
    wait_done(300);
    chk("t4_reload_done_cycle", done_rel, 91);
    repeat (3) tick();

    // start held through a load with stray readdatavalid; drop start in the following idle cycle.
    fill_random();
    stray_pct = 40;
    start = 1'b1;
    n0 = ndone;
    wait_done(400);
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("t5_single_load", ndone - n0, 1);
    chk("t5_done_cycle", done_rel, 91);
    clear_knobs();

    // Randomized back-to-back loads with start held high.
    fill_random();
    wait_pct = 30; lat_max = 3; full_pct = 25; stray_pct = 20;
    start = 1'b1;
    n0 = ndone;
    for (int k = 0; k < 4; k++) wait_done(2000);
    start = 1'b0;
    clear_knobs();
    repeat (20) tick();
    chk("t6_load_count", ndone - n0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
